prg_port_sequencer: RTL and testbench
=====================================

// Module: prg_port_sequencer
// PURPOSE
//  Command-driven controller for the program port (prg_*) of the 256x8 dual-port RAM.
//  Sequences burst WRITE, READ and FILL transfers of 1..256 bytes.
//  Sits between the monitor front end (valid/ready byte streams) and the RAM port b.
//  Runs on the same clock as the RAM port.
// PARAMETERS
//  RD_LATENCY  1  RAM q_b latency in cycles after the address is registered (legal: 1, 2)
// PORTS
//  clock        in   1  single clock, rising edge
//  reset        in   1  asynchronous, active-high
//  cmd_valid    in   1  command offered
//  cmd_ready    out  1  command accepted when cmd_valid & cmd_ready
//  cmd_op       in   2  00 WRITE, 01 READ, 10 FILL, 11 illegal
//  cmd_addr     in   8  start address
//  cmd_len      in   8  byte count minus 1 (0 -> 1 byte, 255 -> 256 bytes)
//  cmd_data     in   8  FILL value
//  wdata_valid  in   1  WRITE stream byte offered
//  wdata_ready  out  1  WRITE stream byte accepted
//  wdata        in   8  WRITE stream byte
//  rdata_valid  out  1  READ stream byte offered
//  rdata_ready  in   1  READ stream byte taken
//  rdata        out  8  READ stream byte
//  prg_we       out  1  RAM port b write enable
//  prg_MA       out  8  RAM port b address
//  prg_WD       out  8  RAM port b write data
//  prg_RD       in   8  RAM port b read data
//  busy         out  1  state != IDLE
//  done         out  1  one-cycle pulse at command completion
//  err          out  1  one-cycle pulse together with done for an illegal op
// BEHAVIOUR
//  - States: IDLE, WRITE, FILL, RD_WAIT, RD_HOLD.
//  - Reset: state=IDLE; ptr=0; cnt=0; rdata=0.
//    Reset values: rdata_valid=0, prg_we=0, prg_MA=0, done=0, err=0, busy=0, cmd_ready=1.
//  - IDLE:
//    - cmd_ready=1.
//    - On accept: ptr<=cmd_addr, cnt<=cmd_len, fill<=cmd_data.
//    - Next state: WRITE, FILL or RD_WAIT by op.
//    - Op 11: stays IDLE; done=1 and err=1 on the next cycle; no RAM access.
//  - Combinational outputs:
//    - prg_MA = ptr.
//    - prg_we = (WRITE & wdata_valid) | FILL.
//    - prg_WD = WRITE ? wdata : fill.
//    - wdata_ready = (state==WRITE).
//  - WRITE: each wdata handshake writes the RAM at that edge.
//    - If cnt==0: go to IDLE.
//    - Else: ptr++, cnt--.
//    - wdata_valid low inserts idle cycles (no write).
//  - FILL: writes one byte every cycle, no stall; len+1 cycles total.
//  - RD_WAIT: lasts RD_LATENCY+1 cycles after ptr settles.
//    - On the last edge: rdata<=prg_RD, rdata_valid<=1, go to RD_HOLD.
//  - RD_HOLD: rdata and rdata_valid held stable until rdata_ready.
//    - On handshake: rdata_valid<=0.
//    - If cnt==0: go to IDLE.
//    - Else: ptr++, cnt--, go to RD_WAIT.
//    - Minimum period is RD_LATENCY+2 cycles per byte.
//  - done: registered pulse, high in the first IDLE cycle after the last write or read handshake.
//  - ptr wraps 0xFF -> 0x00 modulo 256.
//    - A 256-byte command from addr A touches every location once and ends at A-1.
//  - Port b reaches the RAM only.
//    - Addresses 0xFE/0xFF access RAM cells, not oport0/iport0.
//  - A command is never accepted while busy.
//    - cmd_valid while busy is held off by cmd_ready=0.
//  - Reset mid-command: immediate abort to reset values.
//    - Bytes already written remain in RAM; no done pulse.
//  - Simultaneous wdata_valid on the final byte and a new cmd_valid:
//    - The final write completes.
//    - The command is accepted no earlier than the IDLE cycle that follows.
// CONFIGURATION
//  PRG_SEQ_CHECKSUM_EN defined:
//    - Adds output chk[7:0]: 8-bit modulo-256 sum of every byte written (WRITE/FILL) or returned (READ).
//    - chk is cleared on command accept, reset to 0, and stable from the done pulse until the next accept.
//  PRG_SEQ_CHECKSUM_EN undefined:
//    - No chk port and no adder; all other behaviour is identical.
// TESTING
//  1. WRITE addr=0x10 len=3, bytes 11,22,33,44 with a 2-cycle gap before byte 3
//     -> RAM[0x10..0x13]=11,22,33,44; exactly 4 prg_we cycles; one done pulse.
//  2. READ addr=0x10 len=3 with rdata_ready held high
//     -> rdata sequence 11,22,33,44; RD_LATENCY+2 cycles per byte; rdata stable while ready is low.
//  3. FILL addr=0xFE len=3 data=0xA5
//     -> RAM[0xFE,0xFF,0x00,0x01]=A5 (wrap); 4 consecutive prg_we cycles; oport0 unchanged.
//  4. READ len=0, rdata_ready low for 5 cycles then high
//     -> rdata_valid high 5+1 cycles; single byte; done 1 cycle after the handshake.
//  5. Illegal op 11 -> no prg_we, busy stays 0, done=err=1 for one cycle; cmd_valid during FILL is not accepted.
//  6. Assert reset during WRITE after 2 of 4 bytes
//     -> outputs at reset values, 2 bytes in RAM, no done; the next command runs normally.
//     With PRG_SEQ_CHECKSUM_EN, test 1 gives chk=0xAA.

Source files
------------

// File: rtl/prg_port_sequencer.sv
// Burst WRITE / READ / FILL sequencer for the program port (port b) of the 256x8 dual-port RAM.
// Optional build macro PRG_SEQ_CHECKSUM_EN adds the chk[7:0] running byte sum output.
module prg_port_sequencer #(
    parameter int RD_LATENCY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_len,
    input  logic [7:0] cmd_data,
    input  logic       wdata_valid,
    output logic       wdata_ready,
    input  logic [7:0] wdata,
    output logic       rdata_valid,
    input  logic       rdata_ready,
    output logic [7:0] rdata,
    output logic       prg_we,
    output logic [7:0] prg_MA,
    output logic [7:0] prg_WD,
    input  logic [7:0] prg_RD,
    output logic       busy,
    output logic       done,
    output logic       err,
`ifdef PRG_SEQ_CHECKSUM_EN
    output logic [7:0] chk,
`endif
    output logic [2:0] dbg_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WRITE   = 3'd1;
    localparam logic [2:0] FILL    = 3'd2;
    localparam logic [2:0] RD_WAIT = 3'd3;
    localparam logic [2:0] RD_HOLD = 3'd4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;

    // Index of the RD_WAIT cycle whose closing edge samples prg_RD.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY);

    // Handshakes (all stream interfaces): a transfer happens on the rising edge where
    // valid and ready are both high; valid holds its payload stable until that edge.

    logic [2:0] r_state;
    logic [7:0] r_ptr;
    logic [7:0] r_cnt;
    logic [7:0] r_fill;
    logic [7:0] r_rdata;
    logic       r_rdata_valid;
    logic       r_done;
    logic       r_err;
    logic [1:0] r_wait;

    logic w_accept;
    logic w_wr_hs;
    logic w_rd_hs;
    logic w_rd_cap;
    logic w_adv;
    logic w_last;

    assign w_accept = cmd_valid & (r_state == IDLE);
    assign w_wr_hs  = (r_state == WRITE) & wdata_valid;
    assign w_rd_hs  = (r_state == RD_HOLD) & rdata_ready;
    assign w_rd_cap = (r_state == RD_WAIT) & (r_wait == WAIT_LAST);
    // Every byte-consuming event advances the same pointer/count pair.
    assign w_adv    = w_wr_hs | (r_state == FILL) | w_rd_hs;
    assign w_last   = (r_cnt == 8'd0);

    assign cmd_ready   = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign wdata_ready = (r_state == WRITE);
    assign prg_we      = w_wr_hs | (r_state == FILL);
    assign prg_MA      = r_ptr;
    assign prg_WD      = (r_state == WRITE) ? wdata : r_fill;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign done        = r_done;
    assign err         = r_err;
    assign dbg_state   = r_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= 8'd0;
            r_cnt         <= 8'd0;
            r_fill        <= 8'd0;
            r_rdata       <= 8'd0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_wait        <= 2'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_accept) begin
                r_ptr  <= cmd_addr;
                r_cnt  <= cmd_len;
                r_fill <= cmd_data;
                r_wait <= 2'd0;
                case (cmd_op)
                    OP_WRITE: r_state <= WRITE;
                    OP_READ:  r_state <= RD_WAIT;
                    OP_FILL:  r_state <= FILL;
                    default: begin
                        r_done <= 1'b1;
                        r_err  <= 1'b1;
                    end
                endcase
            end

            if (r_state == RD_WAIT) begin
                if (w_rd_cap) begin
                    r_rdata       <= prg_RD;
                    r_rdata_valid <= 1'b1;
                    r_state       <= RD_HOLD;
                end else begin
                    r_wait <= r_wait + 2'd1;
                end
            end

            if (w_rd_hs) begin
                r_rdata_valid <= 1'b0;
                r_wait        <= 2'd0;
                if (!w_last) begin
                    r_state <= RD_WAIT;
                end
            end

            if (w_adv) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + 8'd1;
                    r_cnt <= r_cnt - 8'd1;
                end
            end

            if (r_state > RD_HOLD) begin
                r_state <= IDLE;
            end
        end
    end

`ifdef PRG_SEQ_CHECKSUM_EN
    logic [7:0] r_chk;

    // Written bytes are summed as they hit the RAM, read bytes as they are captured.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chk <= 8'd0;
        end else if (w_accept) begin
            r_chk <= 8'd0;
        end else if (prg_we) begin
            r_chk <= r_chk + prg_WD;
        end else if (w_rd_cap) begin
            r_chk <= r_chk + prg_RD;
        end
    end

    assign chk = r_chk;
`endif

endmodule

// File: tb/tb_prg_port_sequencer.sv
// Randomised scoreboard bench for prg_port_sequencer with a 256x8 RAM port model and a
// memory-array reference model; a negedge monitor pops expected bytes and completions.
module tb_prg_port_sequencer;

    localparam int RD_LAT = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [7:0] cmd_data;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] wdata;
    logic       rdata_valid;
    logic       rdata_ready;
    logic [7:0] rdata;
    logic       prg_we;
    logic [7:0] prg_MA;
    logic [7:0] prg_WD;
    logic [7:0] prg_RD;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] dbg_state;
`ifdef PRG_SEQ_CHECKSUM_EN
    logic [7:0] chk;
`endif

    prg_port_sequencer #(.RD_LATENCY(RD_LAT)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .prg_we(prg_we), .prg_MA(prg_MA), .prg_WD(prg_WD), .prg_RD(prg_RD),
        .busy(busy), .done(done), .err(err),
`ifdef PRG_SEQ_CHECKSUM_EN
        .chk(chk),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / RAM port b model ----------------
    always #5 clock = ~clock;

    logic [7:0] ram [256];
    logic [7:0] ram_areg;
    logic [7:0] ram_q1;

    always @(posedge clock) begin
        if (prg_we) ram[prg_MA] <= prg_WD;
        ram_areg <= prg_MA;
        ram_q1   <= ram[ram_areg];
    end
    assign prg_RD = (RD_LAT == 1) ? ram[ram_areg] : ram_q1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    logic [7:0] exp_rd_q[$];
    logic [0:0] exp_err_q[$];
    logic [8:0] exp_we_q[$];
    logic [7:0] exp_chk_q[$];
    int         hs_cyc[$];
    logic [7:0] ref_mem [256];
    logic [7:0] wbytes [256];
    int         wgaps [256];
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'd0;
    logic       rr_force = 1'b0;
    logic       rr_val = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #2;
        rdata_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (reset) begin
            we_cnt = 0;
            hold_v = 1'b0;
        end else begin
            if (prg_we) we_cnt++;
            if (busy) check("cmd_ready_while_busy", cmd_ready, 0);
            if (rdata_valid) begin
                if (hold_v) check("rdata_stable", rdata, hold_d);
                if (rdata_ready) begin
                    if (exp_rd_q.size() == 0) fail_now("unexpected_rdata");
                    else check("rdata", rdata, exp_rd_q.pop_front());
                    hs_cyc.push_back(cyc);
                    hold_v = 1'b0;
                end else begin
                    hold_v = 1'b1;
                    hold_d = rdata;
                end
            end
            if (done) begin
                if (exp_err_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    check("err", err, exp_err_q.pop_front());
                    check("we_count", we_cnt, exp_we_q.pop_front());
`ifdef PRG_SEQ_CHECKSUM_EN
                    check("chk", chk, exp_chk_q.pop_front());
`else
                    void'(exp_chk_q.pop_front());
`endif
                end
                check("busy_at_done", busy, 0);
                we_cnt = 0;
                done_cnt++;
            end else if (err) begin
                fail_now("err_without_done");
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_write(input logic [7:0] addr, input logic [7:0] len);
        logic [7:0] a = addr;
        logic [7:0] sum = 8'd0;
        for (int i = 0; i <= int'(len); i++) begin
            ref_mem[a] = wbytes[i];
            sum += wbytes[i];
            a++;
        end
        exp_err_q.push_back(1'b0);
        exp_we_q.push_back(9'(len) + 9'd1);
        exp_chk_q.push_back(sum);
    endtask

    task automatic model_fill(input logic [7:0] addr, input logic [7:0] len, input logic [7:0] d);
        logic [7:0] a = addr;
        logic [7:0] sum = 8'd0;
        for (int i = 0; i <= int'(len); i++) begin
            ref_mem[a] = d;
            sum += d;
            a++;
        end
        exp_err_q.push_back(1'b0);
        exp_we_q.push_back(9'(len) + 9'd1);
        exp_chk_q.push_back(sum);
    endtask

    task automatic model_read(input logic [7:0] addr, input logic [7:0] len);
        logic [7:0] a = addr;
        logic [7:0] sum = 8'd0;
        for (int i = 0; i <= int'(len); i++) begin
            exp_rd_q.push_back(ref_mem[a]);
            sum += ref_mem[a];
            a++;
        end
        exp_err_q.push_back(1'b0);
        exp_we_q.push_back(9'd0);
        exp_chk_q.push_back(sum);
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] len,
                         input logic [7:0] d);
        bit ok = 1'b0;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clock);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("cmd_accept_timeout");
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_addr  = 8'($urandom_range(0, 255));
    endtask

    task automatic send_bytes(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wdata_valid = 1'b0;
            repeat (wgaps[i]) begin
                @(posedge clock);
                #1;
            end
            wdata_valid = 1'b1;
            wdata       = wbytes[i];
            ok = 1'b0;
            for (int t = 0; t < 2000; t++) begin
                @(negedge clock);
                if (wdata_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) fail_now("wdata_ready_timeout");
            @(posedge clock);
            #1;
        end
        wdata_valid = 1'b0;
    endtask

    task automatic wait_done(input int tgt);
        bit ok = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            if (done_cnt >= tgt) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
        end
        if (!ok) fail_now("done_timeout");
        #1;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] len);
        int tgt = done_cnt + 1;
        model_write(addr, len);
        issue(2'b00, addr, len, 8'($urandom_range(0, 255)));
        send_bytes(int'(len) + 1);
        wait_done(tgt);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [7:0] len);
        int tgt = done_cnt + 1;
        model_read(addr, len);
        issue(2'b01, addr, len, 8'($urandom_range(0, 255)));
        wait_done(tgt);
    endtask

    task automatic do_fill(input logic [7:0] addr, input logic [7:0] len, input logic [7:0] d);
        int tgt = done_cnt + 1;
        model_fill(addr, len, d);
        issue(2'b10, addr, len, d);
        wait_done(tgt);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdata_valid"}, rdata_valid, 0);
        check({tag, "_prg_we"}, prg_we, 0);
        check({tag, "_prg_MA"}, prg_MA, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_state"}, dbg_state, 0);
`ifdef PRG_SEQ_CHECKSUM_EN
        check({tag, "_chk"}, chk, 0);
`endif
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int tgt;
        logic [7:0] a;
        logic [7:0] l;
        int op;

        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_addr    = 8'd0;
        cmd_len     = 8'd0;
        cmd_data    = 8'd0;
        wdata_valid = 1'b0;
        wdata       = 8'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_vals("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Whole-memory FILL: 256 bytes from a non-zero start, wraps and ends at A-1.
        do_fill(8'h37, 8'hFF, 8'($urandom_range(0, 255)));

        // Directed WRITE with a two-cycle gap before the third byte.
        wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33; wbytes[3] = 8'h44;
        wgaps[0] = 0; wgaps[1] = 0; wgaps[2] = 2; wgaps[3] = 0;
        do_write(8'h10, 8'd3);

        // READ back with ready held high: fixed RD_LAT+2 cycles per byte.
        rr_force = 1'b1;
        rr_val   = 1'b1;
        hs_cyc.delete();
        do_read(8'h10, 8'd3);
        check("rd_burst_bytes", hs_cyc.size(), 4);
        for (int i = 1; i < hs_cyc.size(); i++)
            check("rd_byte_period", hs_cyc[i] - hs_cyc[i-1], RD_LAT + 2);
        rr_force = 1'b0;

        // FILL across the top of memory while a second command is offered.
        tgt = done_cnt + 1;
        model_fill(8'hFE, 8'd3, 8'hA5);
        issue(2'b10, 8'hFE, 8'd3, 8'hA5);
        cmd_op    = 2'b01;
        cmd_valid = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        cmd_valid = 1'b0;
        wait_done(tgt);

        // Single-byte READ held off for five cycles.
        rr_force = 1'b1;
        rr_val   = 1'b0;
        tgt = done_cnt + 1;
        model_read(8'h11, 8'd0);
        issue(2'b01, 8'h11, 8'd0, 8'd0);
        for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            if (rdata_valid) break;
        end
        check("rd_hold_valid_1", rdata_valid, 1);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clock);
            check("rd_hold_valid", rdata_valid, 1);
        end
        @(posedge clock);
        #1;
        rr_val = 1'b1;
        @(posedge clock);
        #1;
        rr_val = 1'b0;
        @(negedge clock);
        check("done_after_rd_hs", done, 1);
        check("rdata_valid_after_hs", rdata_valid, 0);
        wait_done(tgt);
        rr_force = 1'b0;

        // Illegal op: completes immediately with err, touches nothing.
        tgt = done_cnt + 1;
        exp_err_q.push_back(1'b1);
        exp_we_q.push_back(9'd0);
        exp_chk_q.push_back(8'd0);
        issue(2'b11, 8'h55, 8'd9, 8'd0);
        check("illegal_busy", busy, 0);
        wait_done(tgt);

        // Reset after two of four WRITE bytes: no completion, two bytes land.
        for (int i = 0; i < 4; i++) begin
            wbytes[i] = 8'($urandom_range(0, 255));
            wgaps[i]  = $urandom_range(0, 1);
        end
        issue(2'b00, 8'h40, 8'd3, 8'd0);
        send_bytes(2);
        ref_mem[8'h40] = wbytes[0];
        ref_mem[8'h41] = wbytes[1];
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("midreset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midreset_no_done", done_cnt, tgt);

        // Randomised command mix.
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 9);
            a  = 8'($urandom_range(0, 255));
            l  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 7));
            if (op <= 3) begin
                for (int i = 0; i <= int'(l); i++) begin
                    wbytes[i] = 8'($urandom_range(0, 255));
                    wgaps[i]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
                end
                do_write(a, l);
            end else if (op <= 6) begin
                do_read(a, l);
            end else if (op <= 8) begin
                do_fill(a, l, 8'($urandom_range(0, 255)));
            end else begin
                tgt = done_cnt + 1;
                exp_err_q.push_back(1'b1);
                exp_we_q.push_back(9'd0);
                exp_chk_q.push_back(8'd0);
                issue(2'b11, a, l, 8'd0);
                wait_done(tgt);
            end
        end

        repeat (4) @(posedge clock);
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            check("ram_contents", ram[a], ref_mem[a]);
        end
        check("rd_queue_empty", exp_rd_q.size(), 0);
        check("done_queue_empty", exp_err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
